// File: rtl/seq_alu_if.sv
// Handshake bundle for the seq_alu execute unit: operation request channel
// (in_valid/in_ready) and registered result channel (out_valid/out_ready).
interface seq_alu_if #(
  parameter int WIDTH = 32
);
  localparam int SHW = $clog2(WIDTH);

  // Both channels: a transfer happens on a rising clk edge where valid && ready.
  // A producer holding valid keeps its payload stable until the transfer.
  logic             in_valid;
  logic             in_ready;
  logic [5:0]       funct;
  logic [WIDTH-1:0] src1;
  logic [WIDTH-1:0] src2;
  logic [SHW-1:0]   shamt;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             overflow;
  logic             zero;

  modport master (
    output in_valid, funct, src1, src2, shamt, out_ready,
    input  in_ready, out_valid, result, overflow, zero
  );

  modport slave (
    input  in_valid, funct, src1, src2, shamt, out_ready,
    output in_ready, out_valid, result, overflow, zero
  );
endinterface

// File: rtl/seq_alu.sv
// Handshaked execute unit: single-cycle ALU/shift ops plus iterative signed
// MUL (shift-add) and DIV (restoring) on operand magnitudes, WIDTH+1 cycles.
module seq_alu #(
  parameter int WIDTH = 32
) (
  input  logic        clk,
  input  logic        rst,
  seq_alu_if.slave    bus,
  output logic [1:0]  dbg_state
);
  localparam int SHW = $clog2(WIDTH);
  localparam logic [SHW:0]       LAST    = (SHW+1)'(WIDTH);
  localparam logic [WIDTH-1:0]   MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [5:0] F_NOP = 6'b000000, F_ADD = 6'b100000, F_SUB = 6'b100010,
                         F_AND = 6'b100100, F_OR  = 6'b100101, F_XOR = 6'b101000,
                         F_SLT = 6'b101010, F_SLL = 6'b000011, F_SRL = 6'b000010,
                         F_SRA = 6'b000111, F_MUL = 6'b011000, F_DIV = 6'b011010;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_MUL = 2'd1, S_DIV = 2'd2} state_t;
  state_t state, state_next;

  logic             accept, finish;
  logic [SHW:0]     cnt;
  logic             out_valid_q, overflow_q, zero_q;
  logic [WIDTH-1:0] result_q;
  logic [WIDTH-1:0] alu_r;
  logic             alu_o;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [2*WIDTH-1:0] mcand, acc, prod;
  logic [WIDTH-1:0] mplier, quo, rem, dvsr, quot;
  logic [WIDTH:0]   rem_sh, diff;
  logic             neg_res, div_zero, div_ovf;
  logic [WIDTH-1:0] mul_r, div_r;
  logic             mul_o, div_o;

  assign bus.in_ready  = !rst && (state == S_IDLE) && (!out_valid_q || bus.out_ready);
  assign accept        = bus.in_valid && bus.in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.overflow  = overflow_q;
  assign bus.zero      = zero_q;
  assign dbg_state     = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    finish     = 1'b0;
    case (state)
      S_IDLE: begin
        if (accept && bus.funct == F_MUL)      state_next = S_MUL;
        else if (accept && bus.funct == F_DIV) state_next = S_DIV;
      end
      S_MUL, S_DIV: begin
        if (cnt == LAST) begin
          finish     = 1'b1;
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    alu_r = '0;
    alu_o = 1'b0;
    case (bus.funct)
      F_ADD: begin
        alu_r = bus.src1 + bus.src2;
        alu_o = (bus.src1[WIDTH-1] == bus.src2[WIDTH-1]) && (alu_r[WIDTH-1] != bus.src1[WIDTH-1]);
      end
      F_SUB: begin
        alu_r = bus.src1 - bus.src2;
        alu_o = (bus.src1[WIDTH-1] != bus.src2[WIDTH-1]) && (alu_r[WIDTH-1] != bus.src1[WIDTH-1]);
      end
      F_AND: alu_r = bus.src1 & bus.src2;
      F_OR:  alu_r = bus.src1 | bus.src2;
      F_XOR: alu_r = bus.src1 ^ bus.src2;
      F_SLT: alu_r[0] = $signed(bus.src1) < $signed(bus.src2);
      F_SLL: alu_r = bus.src2 << bus.shamt;
      F_SRL: alu_r = bus.src2 >> bus.shamt;
      F_SRA: alu_r = $signed(bus.src2) >>> bus.shamt;
      F_NOP: alu_r = '0;
      default: alu_r = '0;
    endcase
  end

  // The MIN magnitude 2^(WIDTH-1) still fits in WIDTH unsigned bits.
  always_comb begin
    a_mag  = bus.src1[WIDTH-1] ? -bus.src1 : bus.src1;
    b_mag  = bus.src2[WIDTH-1] ? -bus.src2 : bus.src2;
    prod   = neg_res ? -acc : acc;
    mul_r  = prod[WIDTH-1:0];
    mul_o  = prod[2*WIDTH-1:WIDTH] != {WIDTH{prod[WIDTH-1]}};
    rem_sh = {rem, quo[WIDTH-1]};
    diff   = rem_sh - {1'b0, dvsr};
    quot   = neg_res ? -quo : quo;
    div_r  = div_zero ? '1 : quot;
    div_o  = div_zero || div_ovf;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      overflow_q  <= 1'b0;
      zero_q      <= 1'b0;
      cnt         <= '0;
      mcand       <= '0;
      acc         <= '0;
      mplier      <= '0;
      quo         <= '0;
      rem         <= '0;
      dvsr        <= '0;
      neg_res     <= 1'b0;
      div_zero    <= 1'b0;
      div_ovf     <= 1'b0;
    end else if (accept) begin
      cnt     <= '0;
      neg_res <= bus.src1[WIDTH-1] ^ bus.src2[WIDTH-1];
      if (bus.funct == F_MUL) begin
        mcand       <= {{WIDTH{1'b0}}, a_mag};
        mplier      <= b_mag;
        acc         <= '0;
        out_valid_q <= 1'b0;
      end else if (bus.funct == F_DIV) begin
        quo         <= a_mag;
        rem         <= '0;
        dvsr        <= b_mag;
        div_zero    <= (bus.src2 == '0);
        div_ovf     <= (bus.src1 == MIN_VAL) && (bus.src2 == '1);
        out_valid_q <= 1'b0;
      end else begin
        result_q    <= alu_r;
        overflow_q  <= alu_o;
        zero_q      <= (alu_r == '0);
        out_valid_q <= 1'b1;
      end
    end else if (finish) begin
      result_q    <= (state == S_MUL) ? mul_r : div_r;
      overflow_q  <= (state == S_MUL) ? mul_o : div_o;
      zero_q      <= (state == S_MUL) ? (mul_r == '0) : (div_r == '0);
      out_valid_q <= 1'b1;
    end else begin
      if (out_valid_q && bus.out_ready) out_valid_q <= 1'b0;
      if (state == S_MUL) begin
        if (mplier[0]) acc <= acc + mcand;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt + 1'b1;
      end else if (state == S_DIV) begin
        // diff[WIDTH] is the borrow: clear means the shifted remainder >= divisor.
        rem <= diff[WIDTH] ? rem_sh[WIDTH-1:0] : diff[WIDTH-1:0];
        quo <= {quo[WIDTH-2:0], ~diff[WIDTH]};
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_seq_alu.sv
// Directed and randomized bench for seq_alu: a 64-bit arithmetic reference
// model feeds an expected queue that is drained whenever a result is taken.
module tb_seq_alu;
  localparam int W   = 32;
  localparam int SHW = 5;
  localparam logic [5:0] F_NOP = 6'b000000, F_ADD = 6'b100000, F_SUB = 6'b100010,
                         F_AND = 6'b100100, F_OR  = 6'b100101, F_XOR = 6'b101000,
                         F_SLT = 6'b101010, F_SLL = 6'b000011, F_SRL = 6'b000010,
                         F_SRA = 6'b000111, F_MUL = 6'b011000, F_DIV = 6'b011010;
  localparam longint MAXI = (longint'(1) <<< (W-1)) - 1;
  localparam longint MINI = -(longint'(1) <<< (W-1));

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] dbg_state;
  seq_alu_if #(.WIDTH(W)) bus ();

  seq_alu #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  logic [W+1:0] exp_q[$];
  logic [W+1:0] mon_e;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: {result, overflow, zero} from wide signed arithmetic.
  function automatic logic [W+1:0] model(input logic [5:0] f, input logic [W-1:0] a,
                                         input logic [W-1:0] b, input logic [SHW-1:0] sh);
    longint sa, sb, r;
    logic   o;
    logic [W-1:0] res;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r  = 0;
    o  = 1'b0;
    case (f)
      F_ADD: begin r = sa + sb; o = (r > MAXI) || (r < MINI); end
      F_SUB: begin r = sa - sb; o = (r > MAXI) || (r < MINI); end
      F_AND: r = longint'(a & b);
      F_OR:  r = longint'(a | b);
      F_XOR: r = longint'(a ^ b);
      F_SLT: r = (sa < sb) ? 1 : 0;
      F_SLL: r = longint'(b) << sh;
      F_SRL: r = longint'(b) >> sh;
      F_SRA: r = sb >>> sh;
      F_MUL: begin r = sa * sb; o = (r > MAXI) || (r < MINI); end
      F_DIV: begin
        if (sb == 0) begin r = -1; o = 1'b1; end
        else begin r = sa / sb; o = (r > MAXI); end
      end
      default: r = 0;
    endcase
    res = r[W-1:0];
    return {res, o, (res == '0)};
  endfunction

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      check("result_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        check("result_flags", {bus.result, bus.overflow, bus.zero}, mon_e);
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called just after a rising edge; returns 1ns after the accepting edge.
  task automatic issue(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [SHW-1:0] sh, output int waits);
    bus.funct    = f;
    bus.src1     = a;
    bus.src2     = b;
    bus.shamt    = sh;
    bus.in_valid = 1'b1;
    waits = 0;
    @(negedge clk);
    while (!bus.in_ready && waits < 200) begin
      @(negedge clk);
      waits++;
    end
    if (waits >= 200) check("accept_timeout", 64'(waits), 64'd0);
    @(posedge clk);
    if (waits < 200) exp_q.push_back(model(f, a, b, sh));
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_result(output int edges, output int ready_hi);
    edges = 0;
    ready_hi = 0;
    while (!bus.out_valid && edges < 100) begin
      if (bus.in_ready) ready_hi++;
      @(posedge clk);
      #1;
      edges++;
    end
  endtask

  function automatic logic [W-1:0] pick_operand();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'h7FFF_FFFF;
      4: return 32'($signed($urandom_range(0, 40)) - 20);
      default: return 32'($urandom);
    endcase
  endfunction

  logic [5:0] codes [12] = '{F_NOP, F_ADD, F_SUB, F_AND, F_OR, F_XOR,
                             F_SLT, F_SLL, F_SRL, F_SRA, F_MUL, F_DIV};

  // ---------------- directed + random sequence ----------------
  initial begin
    int w, edges, rdy;
    int stall_bad;
    logic [5:0] f;

    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    bus.funct = '0;
    bus.src1 = '0;
    bus.src2 = '0;
    bus.shamt = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_result", bus.result, 0);
    check("rst_overflow", bus.overflow, 0);
    check("rst_zero", bus.zero, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("idle_in_ready", bus.in_ready, 1);

    issue(F_ADD, 32'h7FFF_FFFF, 32'h1, 0, w);
    check("add_latency", bus.out_valid, 1);
    check("add_max_result", bus.result, 32'h8000_0000);
    check("add_max_ovf", bus.overflow, 1);

    issue(F_SUB, 32'h8000_0000, 32'h1, 0, w);
    check("sub_min_result", bus.result, 32'h7FFF_FFFF);
    check("sub_min_ovf", bus.overflow, 1);
    issue(F_SUB, 32'd5, 32'd5, 0, w);
    check("sub_eq_zero", {bus.result, bus.overflow, bus.zero}, {32'h0, 1'b0, 1'b1});

    issue(F_MUL, 32'hFFFF_FFFD, 32'd7, 0, w);
    check("mul_busy_state", 64'(dbg_state != 2'd0), 1);
    wait_result(edges, rdy);
    check("mul_latency", edges, 33);
    check("mul_neg_result", {bus.result, bus.overflow}, {32'hFFFF_FFEB, 1'b0});

    issue(F_MUL, 32'h0001_0000, 32'h0001_0000, 0, w);
    wait_result(edges, rdy);
    check("mul_big", {bus.result, bus.overflow, bus.zero}, {32'h0, 1'b1, 1'b1});

    issue(F_DIV, 32'hFFFF_FFF9, 32'd2, 0, w);
    wait_result(edges, rdy);
    check("div_trunc", {bus.result, bus.overflow}, {32'hFFFF_FFFD, 1'b0});

    issue(F_DIV, 32'd9, 32'd0, 0, w);
    wait_result(edges, rdy);
    check("div0_latency", edges, 33);
    check("div0_ready_low", rdy, 0);
    check("div0_result", {bus.result, bus.overflow}, {32'hFFFF_FFFF, 1'b1});

    issue(F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, w);
    wait_result(edges, rdy);
    check("div_min_m1", {bus.result, bus.overflow}, {32'h8000_0000, 1'b1});

    // Hold a result for five cycles, then stream three ops back to back.
    issue(F_ADD, 32'd10, 32'd20, 0, w);
    bus.out_ready = 1'b0;
    stall_bad = 0;
    repeat (5) begin
      @(posedge clk);
      #1;
      if (bus.result !== 32'd30 || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) stall_bad++;
    end
    check("stall_hold", stall_bad, 0);
    bus.out_ready = 1'b1;
    issue(F_AND, 32'hF0F0_1234, 32'h0FF0_FFFF, 0, w);
    check("b2b_and_wait", w, 0);
    check("b2b_and_valid", bus.out_valid, 1);
    issue(F_OR, 32'hF000_0000, 32'h0000_000F, 0, w);
    check("b2b_or_wait", w, 0);
    issue(F_SRA, 32'h0, 32'h8000_0000, 5'd4, w);
    check("b2b_sra_wait", w, 0);
    check("b2b_sra_result", bus.result, 32'hF800_0000);

    // Reset in the middle of a divide.
    issue(F_DIV, 32'd100, 32'd7, 0, w);
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("midrst_out_valid", bus.out_valid, 0);
    check("midrst_result", bus.result, 0);
    check("midrst_in_ready", bus.in_ready, 0);
    check("midrst_state_idle", dbg_state, 0);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    issue(F_ADD, 32'd1, 32'd2, 0, w);
    check("post_rst_add", bus.result, 32'd3);

    // Randomized ops with occasional consumer stalls.
    for (int i = 0; i < 60; i++) begin
      f = ($urandom_range(0, 9) == 0) ? 6'($urandom) : codes[$urandom_range(0, 11)];
      issue(f, pick_operand(), pick_operand(), 5'($urandom), w);
      if ($urandom_range(0, 3) == 0) begin
        bus.out_ready = 1'b0;
        repeat ($urandom_range(1, 4)) begin
          @(posedge clk);
          #1;
        end
        bus.out_ready = 1'b1;
      end
    end

    edges = 0;
    while (exp_q.size() != 0 && edges < 100) begin
      @(posedge clk);
      #1;
      edges++;
    end
    check("drain_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
